// File: rtl/wb_sram_ctrl.sv
// Wishbone B4 pipelined slave that maps each 32-bit access onto one or two
// 16-bit accesses of an external asynchronous SRAM. Each half has an ACC
// phase lasting WAIT_STATES+1 cycles followed by a one-cycle HOLD phase.
// Only one transaction is in flight at a time. Every SRAM pin is a flop
// output, so the pads see clean, glitch-free strobes.
//
// Handshake: a request transfers on a rising CLK edge when
// WB_CYC_IN & WB_STB_IN & ~WB_STALL_OUT. STALL is low only in IDLE, so at most
// one request is accepted before its response. The response is a single-cycle
// WB_ACK_OUT or WB_ERR_OUT, and it is issued only while WB_CYC_IN is still high.
module wb_sram_ctrl #(
    parameter int SRAM_AW     = 18,
    parameter int WAIT_STATES = 1
) (
    input  logic               CLK,
    input  logic               RST_SYNC_N,
    input  logic               EN,
    input  logic [31:0]        WB_ADR_IN,
    input  logic               WB_CYC_IN,
    input  logic               WB_STB_IN,
    input  logic               WB_WE_IN,
    input  logic [3:0]         WB_SEL_IN,
    input  logic [2:0]         WB_CTI_IN,
    input  logic [1:0]         WB_BTE_IN,
    output logic               WB_STALL_OUT,
    output logic               WB_ACK_OUT,
    output logic               WB_ERR_OUT,
    output logic [31:0]        WB_DAT_RD_OUT,
    input  logic [31:0]        WB_DAT_WR_IN,
    output logic [SRAM_AW-1:0] SRAM_ADR_OUT,
    input  logic [15:0]        SRAM_DQ_IN,
    output logic [15:0]        SRAM_DQ_OUT,
    output logic               SRAM_DQ_OE_OUT,
    output logic               SRAM_CE_N_OUT,
    output logic               SRAM_OE_N_OUT,
    output logic               SRAM_WE_N_OUT,
    output logic               SRAM_UB_N_OUT,
    output logic               SRAM_LB_N_OUT
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LO_ACC  = 3'd1,
        LO_HOLD = 3'd2,
        HI_ACC  = 3'd3,
        HI_HOLD = 3'd4,
        RESP    = 3'd5
    } state_t;

    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

    // Burst type, cycle type and the byte lane of the address do not affect
    // behaviour: every access is handled as a classic single cycle.
    logic unused_sigs;
    assign unused_sigs = ^{WB_CTI_IN, WB_BTE_IN, WB_ADR_IN[1:0]};

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [SRAM_AW-2:0] word_q, word_d;
    logic               we_q, we_d;
    logic [3:0]         sel_q, sel_d;
    logic [31:0]        wdat_q, wdat_d;
    logic               rsp_err_q, rsp_err_d;
    logic [31:0]        rdat_q, rdat_d;
    logic [SRAM_AW-1:0] adr_q, adr_d;
    logic [15:0]        dq_out_q, dq_out_d;
    logic               dq_oe_q, dq_oe_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic               ub_n_q, ub_n_d;
    logic               lb_n_q, lb_n_d;
    logic               stall_q, stall_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;

    logic accept;
    logic out_of_range;
    logic in_lo, in_hi, in_acc;

    assign accept       = WB_CYC_IN & WB_STB_IN & ~stall_q & (state_q == IDLE);
    assign out_of_range = |WB_ADR_IN[31:SRAM_AW+1];

    // Next state, request capture, wait counter and read-data capture.
    // The registered outputs are then derived from the next state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        we_d      = we_q;
        sel_d     = sel_q;
        wdat_d    = wdat_q;
        rsp_err_d = rsp_err_q;
        rdat_d    = rdat_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    word_d    = WB_ADR_IN[SRAM_AW:2];
                    we_d      = WB_WE_IN;
                    sel_d     = WB_SEL_IN;
                    wdat_d    = WB_DAT_WR_IN;
                    cnt_d     = WS_LOAD;
                    rsp_err_d = 1'b0;
                    if (out_of_range) begin
                        rsp_err_d = 1'b1;
                        state_d   = RESP;
                    end else if (!WB_WE_IN || (|WB_SEL_IN[1:0])) begin
                        state_d = LO_ACC;
                    end else if (|WB_SEL_IN[3:2]) begin
                        state_d = HI_ACC;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            LO_ACC: begin
                if (cnt_q == 4'd0) begin
                    state_d = LO_HOLD;
                    if (!we_q) begin
                        rdat_d[15:0] = SRAM_DQ_IN;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            LO_HOLD: begin
                if (!we_q || (|sel_q[3:2])) begin
                    state_d = HI_ACC;
                    cnt_d   = WS_LOAD;
                end else begin
                    state_d = RESP;
                end
            end
            HI_ACC: begin
                if (cnt_q == 4'd0) begin
                    state_d = HI_HOLD;
                    if (!we_q) begin
                        rdat_d[31:16] = SRAM_DQ_IN;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HI_HOLD: state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_lo  = (state_d == LO_ACC) || (state_d == LO_HOLD);
    assign in_hi  = (state_d == HI_ACC) || (state_d == HI_HOLD);
    assign in_acc = (state_d == LO_ACC) || (state_d == HI_ACC);

    // Registered pad and bus outputs as seen in the upcoming state.
    // Address and write data simply hold outside an access.
    always_comb begin
        adr_d    = adr_q;
        dq_out_d = dq_out_q;
        ub_n_d   = 1'b1;
        lb_n_d   = 1'b1;
        ce_n_d   = ~(in_lo | in_hi);
        oe_n_d   = ~(in_acc & ~we_d);
        we_n_d   = ~(in_acc & we_d);
        dq_oe_d  = (in_lo | in_hi) & we_d;
        if (in_lo) begin
            adr_d    = {word_d, 1'b0};
            dq_out_d = wdat_d[15:0];
            lb_n_d   = we_d ? ~sel_d[0] : 1'b0;
            ub_n_d   = we_d ? ~sel_d[1] : 1'b0;
        end else if (in_hi) begin
            adr_d    = {word_d, 1'b1};
            dq_out_d = wdat_d[31:16];
            lb_n_d   = we_d ? ~sel_d[2] : 1'b0;
            ub_n_d   = we_d ? ~sel_d[3] : 1'b0;
        end
        stall_d = (state_d != IDLE);
        ack_d   = (state_d == RESP) & ~rsp_err_d & WB_CYC_IN;
        err_d   = (state_d == RESP) & rsp_err_d & WB_CYC_IN;
    end

    // State and output registers; reset wins over the clock enable.
    always_ff @(posedge CLK) begin
        if (!RST_SYNC_N) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            word_q    <= '0;
            we_q      <= 1'b0;
            sel_q     <= 4'd0;
            wdat_q    <= 32'd0;
            rsp_err_q <= 1'b0;
            rdat_q    <= 32'd0;
            adr_q     <= '0;
            dq_out_q  <= 16'd0;
            dq_oe_q   <= 1'b0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            ub_n_q    <= 1'b1;
            lb_n_q    <= 1'b1;
            stall_q   <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else if (EN) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            wdat_q    <= wdat_d;
            rsp_err_q <= rsp_err_d;
            rdat_q    <= rdat_d;
            adr_q     <= adr_d;
            dq_out_q  <= dq_out_d;
            dq_oe_q   <= dq_oe_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            ub_n_q    <= ub_n_d;
            lb_n_q    <= lb_n_d;
            stall_q   <= stall_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign WB_STALL_OUT   = stall_q;
    assign WB_ACK_OUT     = ack_q;
    assign WB_ERR_OUT     = err_q;
    assign WB_DAT_RD_OUT  = rdat_q;
    assign SRAM_ADR_OUT   = adr_q;
    assign SRAM_DQ_OUT    = dq_out_q;
    assign SRAM_DQ_OE_OUT = dq_oe_q;
    assign SRAM_CE_N_OUT  = ce_n_q;
    assign SRAM_OE_N_OUT  = oe_n_q;
    assign SRAM_WE_N_OUT  = we_n_q;
    assign SRAM_UB_N_OUT  = ub_n_q;
    assign SRAM_LB_N_OUT  = lb_n_q;

endmodule

// File: doc/wb_sram_ctrl.md
Name: wb_sram_ctrl

Overview:
Wishbone B4 pipelined slave that is the destination-side consumer of the clock-domain sync bridge's master port. It converts each 32-bit WB access into one or two 16-bit accesses on an external asynchronous SRAM, with a programmable number of wait states. One transaction is outstanding at a time. All SRAM control strobes are driven directly from registers.

Parameters:
SRAM_AW, 18, SRAM half-word address width. Addressable space is 2^(SRAM_AW+1) bytes.
WAIT_STATES, 1, extra cycles the strobe is held low per half access (0..15).

Ports:
CLK  in  1  clock
RST_SYNC_N  in  1  synchronous active-low reset
EN  in  1  clock enable; when low, all state, counters and outputs hold
WB_ADR_IN  in  32  byte address; [1:0] ignored
WB_CYC_IN  in  1  cycle
WB_STB_IN  in  1  strobe
WB_WE_IN  in  1  write enable
WB_SEL_IN  in  4  byte selects
WB_CTI_IN  in  3  ignored; every access is treated as classic
WB_BTE_IN  in  2  ignored
WB_STALL_OUT  out  1  stall
WB_ACK_OUT  out  1  one-cycle acknowledge
WB_ERR_OUT  out  1  one-cycle error
WB_DAT_RD_OUT  out  32  read data
WB_DAT_WR_IN  in  32  write data
SRAM_ADR_OUT  out  SRAM_AW  half-word address
SRAM_DQ_IN  in  16  data from pad
SRAM_DQ_OUT  out  16  data to pad
SRAM_DQ_OE_OUT  out  1  pad output enable, active high
SRAM_CE_N_OUT  out  1  chip enable
SRAM_OE_N_OUT  out  1  output enable
SRAM_WE_N_OUT  out  1  write enable
SRAM_UB_N_OUT  out  1  upper byte enable
SRAM_LB_N_OUT  out  1  lower byte enable

Behaviour:
- Clocking and reset: single clock CLK; reset is synchronous and active-low (RST_SYNC_N). RST_SYNC_N takes priority over EN.
- Reset values:
  - CE_N, OE_N, WE_N, UB_N, LB_N = 1.
  - DQ_OE = 0; ADR = 0; DQ_OUT = 0.
  - ACK, ERR, STALL = 0; DAT_RD = 0.
  - State = IDLE.
- Reset mid-transaction: the reset takes effect on the next edge. Strobes go high immediately and no ACK is issued.
- States: IDLE, LO_ACC, LO_HOLD, HI_ACC, HI_HOLD, RESP.
- STALL is 0 only in IDLE. A request (CYC & STB & ~STALL) is accepted in IDLE. ADR, WE, SEL and DAT_WR are captured on the accept edge.
- Address decode:
  - Out of range when ADR[31:SRAM_AW+1] != 0. The block then goes to RESP with ERR=1, performs no SRAM access and leaves DAT_RD unchanged.
  - Low half uses SRAM address {ADR[SRAM_AW:2],0} and data [15:0]. High half uses {ADR[SRAM_AW:2],1} and data [31:16].
- Half selection:
  - Reads always perform LO then HI, with UB_N=LB_N=0.
  - Writes perform LO only if SEL[1:0]!=0 and HI only if SEL[3:2]!=0. Byte enables follow the selects: LB_N=~SEL[0]/~SEL[2], UB_N=~SEL[1]/~SEL[3].
  - A write with SEL=0 goes straight to RESP with ACK.
- x_ACC (WAIT_STATES+1 cycles):
  - CE_N=0; OE_N=0 for reads or WE_N=0 for writes.
  - For writes, DQ_OE=1 and DQ_OUT carries the selected half.
  - On a read, DQ_IN is captured into the matching DAT_RD half on the last ACC cycle.
- x_HOLD (1 cycle): CE_N=0, OE_N=WE_N=1, address and DQ_OUT/DQ_OE held. This gives write data hold time and read turnaround.
- Transitions: LO_HOLD goes to HI_ACC if the HI half is needed, else to RESP. HI_HOLD goes to RESP. RESP lasts 1 cycle, then IDLE.
- ACK/ERR are asserted for exactly the RESP cycle, and only if CYC is still high in the cycle they would assert.
- CYC dropped mid-transaction: the SRAM access runs to completion (no partial-write abort) and the response is suppressed.
- Latency from the accept edge to ACK high: 2*(WAIT_STATES+2)+1 cycles for a read or 2-half write; WAIT_STATES+3 for a 1-half write; 1 for ERR or a SEL=0 write.
- The wait counter is 4 bits. It is reloaded on entry to each ACC phase and does not free-run.
- EN low freezes the FSM, the counter and all registered outputs, including ACK.

Test Plan:
1. Read, WAIT_STATES=1: SRAM model holds 0x1234 at hw 0x10 and 0xABCD at hw 0x11; read ADR=0x20 -> OE_N low 2 cycles per half; ACK exactly 7 cycles after accept; DAT_RD=0xABCD1234; WE_N stays 1.
2. Full write ADR=0x40, SEL=0xF, DAT=0xDEADBEEF -> hw 0x20=0xBEEF then hw 0x21=0xDEAD; DQ_OE=1 for ACC+HOLD of each half; single-cycle ACK.
3. Byte write SEL=0x4, DAT=0x00770000 to ADR=0x40 -> only the HI half is accessed with LB_N=0, UB_N=1; SRAM becomes 0xDE77; ACK 4 cycles after accept.
4. Out of range: SRAM_AW=18, ADR=0x0008_0000 -> ERR high 1 cycle the cycle after accept; CE_N never low; ACK stays 0.
5. Drop CYC during LO_ACC of a 2-half write -> both halves are still written; no ACK/ERR; STALL returns to 0 and the next request is accepted normally.
6. EN toggling 1-of-3 cycles during a read, plus RST_SYNC_N low during HI_ACC -> results match the EN=1 run in enabled cycles; after reset all strobes are 1, STALL=0, no ACK.
